// File: rtl/arr_pkg.sv
// Shared definitions for the two-port array RAM arbiter.
// Requester indices, default widths and the arbiter state encoding.
package arr_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 8;
    localparam int N_REQ         = 2;
    localparam int REQ_CPU       = 0;
    localparam int REQ_DMA       = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_lock_arb.sv
// Two-way round-robin arbiter with lockable bursts.
// Grant is combinational from req; ownership and fairness state are registered.
module rr_lock_arb
    import arr_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any;
    logic             gnt_idx;
    logic             cont;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        any     = 1'b0;
        gnt_idx = 1'b0;
        if (state_q == ST_OWNED && req[owner_q]) begin
            any     = 1'b1;
            gnt_idx = owner_q;
        end else if (&req) begin
            any     = 1'b1;
            gnt_idx = ~last_q;
        end else if (req[REQ_CPU]) begin
            any     = 1'b1;
            gnt_idx = 1'b0;
        end else if (req[REQ_DMA]) begin
            any     = 1'b1;
            gnt_idx = 1'b1;
        end

        cont    = (state_q == ST_OWNED) && any && (gnt_idx == owner_q);
        cnt_inc = cnt_q + CNT_W'(1);

        state_d = ST_IDLE;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = '0;
        if (any) begin
            last_d = gnt_idx;
            // A continuing owner releases on lock drop or when the burst fills.
            if (cont) begin
                if (lock[gnt_idx] && cnt_inc < CNT_W'(MAX_BURST)) begin
                    state_d = ST_OWNED;
                    cnt_d   = cnt_inc;
                end
            end else if (lock[gnt_idx] && MAX_BURST > 1) begin
                state_d = ST_OWNED;
                owner_d = gnt_idx;
                cnt_d   = CNT_W'(1);
            end
        end

        gnt = {any & gnt_idx, any & ~gnt_idx} & {2{~rst}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/array_ram_arbiter.sv
// Shares one single-port array RAM between the CPU data port and DMA port.
// Muxes the granted command onto the RAM and returns read data one cycle later.
module array_ram_arbiter
    import arr_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_lock,
    input  logic [1:0]             m_we,
    input  logic [1:0][ADDR_W-1:0] m_addr,
    input  logic [1:0][DATA_W-1:0] m_wdata,
    input  logic [1:0][DATA_W/8-1:0] m_be,
    output logic [1:0]             m_gnt,
    output logic [1:0]             m_rvalid,
    output logic [DATA_W-1:0]      m_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic [DATA_W/8-1:0]    ram_be,
    input  logic [DATA_W-1:0]      ram_rdata
);

    logic [1:0] gnt;
    logic       acc;
    logic       sel;
    logic [1:0] rvalid_q, rvalid_d;

    rr_lock_arb #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (m_req),
        .lock(m_lock),
        .gnt (gnt)
    );

    always_comb begin
        m_gnt     = gnt;
        acc       = |(m_req & gnt);
        sel       = gnt[REQ_DMA];
        ram_en    = acc;
        ram_we    = acc & m_we[sel];
        ram_addr  = acc ? m_addr[sel] : '0;
        ram_wdata = acc ? m_wdata[sel] : '0;
        ram_be    = acc ? m_be[sel] : '0;
        rvalid_d  = m_req & gnt & ~m_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    // Gate with rst so a read in flight when reset hits never surfaces.
    always_comb begin
        m_rvalid = rvalid_q & {2{~rst}};
        m_rdata  = (|m_rvalid) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_array_ram_arbiter.sv
// Randomized and directed bench for array_ram_arbiter with a RAM model
// and a grant/data reference model kept at transaction level.
module tb_array_ram_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int MB  = 8;
    localparam int NW  = 4096;

    logic               clk;
    logic               rst;
    logic [1:0]         m_req;
    logic [1:0]         m_lock;
    logic [1:0]         m_we;
    logic [1:0][AW-1:0] m_addr;
    logic [1:0][DW-1:0] m_wdata;
    logic [1:0][3:0]    m_be;
    logic [1:0]         m_gnt;
    logic [1:0]         m_rvalid;
    logic [DW-1:0]      m_rdata;
    logic               ram_en;
    logic               ram_we;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic [3:0]         ram_be;
    logic [DW-1:0]      ram_rdata;

    array_ram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_lock(m_lock), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int a);
        if (a == 'h010) return 32'hDEADBEEF;
        return (32'(a) << 12) ^ 32'(a) ^ 32'hA500_0000;
    endfunction

    logic [31:0] mem [NW];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    int          own;
    int          burst;
    int          last;
    int          prev_g;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    logic [31:0] ref_mem [NW];

    task automatic model_reset();
        own    = -1;
        burst  = 0;
        last   = 1;
        prev_g = -1;
        exp_rv = 2'b00;
        exp_rd = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    endtask

    function automatic int predict();
        if (own >= 0 && m_req[own]) return own;
        if (m_req == 2'b11) return 1 - last;
        if (m_req[0]) return 0;
        if (m_req[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        prev_g = g;
        exp_rv = 2'b00;
        if (g < 0) begin
            own   = -1;
            burst = 0;
            return;
        end
        if (m_we[g]) begin
            for (int b = 0; b < 4; b++)
                if (m_be[g][b])
                    ref_mem[m_addr[g]][8*b +: 8] = m_wdata[g][8*b +: 8];
        end else begin
            exp_rv = 2'b01 << g;
            exp_rd = ref_mem[m_addr[g]];
        end
        if (own == g) begin
            burst++;
            if (!m_lock[g] || burst >= MB) begin
                own   = -1;
                burst = 0;
            end
        end else if (m_lock[g]) begin
            own   = g;
            burst = 1;
        end else begin
            own   = -1;
            burst = 0;
        end
        last = g;
    endtask

    task automatic cycle(input logic [1:0] want, input bit use_want);
        int         g;
        logic [1:0] eg;
        #2;
        g  = predict();
        eg = (g < 0) ? 2'b00 : (2'b01 << g);
        chk("gnt", m_gnt, eg);
        if (use_want) chk("gnt_dir", m_gnt, want);
        chk("ram_en", ram_en, g >= 0);
        if (g >= 0) begin
            chk("ram_we", ram_we, m_we[g]);
            chk("ram_addr", ram_addr, m_addr[g]);
            if (m_we[g]) begin
                chk("ram_wdata", ram_wdata, m_wdata[g]);
                chk("ram_be", ram_be, m_be[g]);
            end
        end
        chk("rvalid", m_rvalid, exp_rv);
        if (exp_rv != 2'b00) chk("rdata", m_rdata, exp_rd);
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            #2;
            chk("rst_gnt", m_gnt, 2'b00);
            chk("rst_ram_en", ram_en, 1'b0);
            chk("rst_rvalid", m_rvalid, 2'b00);
            chk("rst_rdata", m_rdata, 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_inputs();
        m_req   = 2'b00;
        m_lock  = 2'b00;
        m_we    = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
    endtask

    logic [31:0] w036;
    logic [1:0]  w;

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        m_req = 2'b11;
        do_reset(3);
        idle_inputs();

        m_req     = 2'b01;
        m_addr[0] = 12'h010;
        cycle(2'b01, 1'b1);
        m_req = 2'b00;
        #1;
        chk("rv_033", m_rvalid, 2'b01);
        chk("rd_033", m_rdata, 32'hDEADBEEF);
        cycle(2'b00, 1'b0);

        do_reset(2);
        m_req     = 2'b11;
        m_addr[0] = 12'h001;
        m_addr[1] = 12'h002;
        for (int i = 0; i < 8; i++) begin
            w = (i % 2 == 0) ? 2'b01 : 2'b10;
            cycle(w, 1'b1);
        end
        idle_inputs();
        cycle(2'b00, 1'b0);

        do_reset(2);
        m_req = 2'b01;
        cycle(2'b01, 1'b1);
        m_req  = 2'b11;
        m_lock = 2'b10;
        for (int i = 0; i < 8; i++) cycle(2'b10, 1'b1);
        cycle(2'b01, 1'b1);
        idle_inputs();
        cycle(2'b00, 1'b0);

        do_reset(2);
        m_req      = 2'b01;
        m_we       = 2'b01;
        m_addr[0]  = 12'hFFF;
        m_wdata[0] = 32'h12345678;
        m_be[0]    = 4'b0011;
        cycle(2'b01, 1'b1);
        m_req     = 2'b10;
        m_we      = 2'b00;
        m_addr[1] = 12'hFFF;
        cycle(2'b10, 1'b1);
        m_req = 2'b00;
        w036  = init_word(12'hFFF);
        #1;
        chk("rv_036", m_rvalid, 2'b10);
        chk("rd_036", m_rdata, {w036[31:16], 16'h5678});
        idle_inputs();
        cycle(2'b00, 1'b0);

        do_reset(2);
        m_req     = 2'b01;
        m_addr[0] = 12'h020;
        cycle(2'b01, 1'b1);
        do_reset(1);
        cycle(2'b01, 1'b1);
        m_req = 2'b00;
        cycle(2'b00, 1'b0);

        do_reset(2);
        m_req = 2'b01;
        cycle(2'b01, 1'b1);
        m_req  = 2'b11;
        m_lock = 2'b10;
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1);
        m_lock = 2'b00;
        m_req  = 2'b01;
        cycle(2'b01, 1'b1);
        idle_inputs();
        cycle(2'b00, 1'b0);

        do_reset(2);
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1);
                prev_g = -1;
            end
            for (int i = 0; i < 2; i++) begin
                if (!(m_req[i] && prev_g != i)) begin
                    m_req[i]   = ($urandom_range(0, 3) != 0);
                    m_lock[i]  = ($urandom_range(0, 2) == 0);
                    m_we[i]    = $urandom_range(0, 1) == 1;
                    m_addr[i]  = AW'($urandom_range(0, 15));
                    m_wdata[i] = $urandom;
                    m_be[i]    = 4'($urandom_range(0, 15));
                end
            end
            cycle(2'b00, 1'b0);
        end
        idle_inputs();
        cycle(2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
